// File: rtl/snow64_alu_arbiter.sv
// snow64_alu_arbiter
//   Shares one Snow64 ALU datapath between NUM_REQ requesters.
//   A combinational round-robin arbiter accepts at most one request per cycle.
//   The winning request is registered onto the ALU interface. Unused opcodes
//   are screened out so the ALU never sees them. A tag pipeline matched to
//   ALU_LATENCY routes each result back to its requester in issue order.
//
// Ports
//   clk, rst_n          clock and synchronous active-low reset
//   in_req_valid/ready  per-requester handshake (ready is one-hot or zero)
//   in_req_a/b          packed 64-bit operands, requester i at [64i+63:64i]
//   in_req_oper         packed 4-bit opcodes
//   in_req_type_size    packed 2-bit type sizes
//   in_req_signedness   per-requester signedness
//   out_alu_*           registered operation presented to the shared ALU
//   in_alu_data         ALU result, ALU_LATENCY cycles after out_alu_*
//   out_res_valid       one-hot result strobe per requester
//   out_res_data        result data, zero for rejected opcodes
//   out_res_illegal     the result belongs to a rejected opcode
module snow64_alu_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int ALU_LATENCY = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     in_req_valid,
  output logic [NUM_REQ-1:0]     in_req_ready,
  input  logic [NUM_REQ*64-1:0]  in_req_a,
  input  logic [NUM_REQ*64-1:0]  in_req_b,
  input  logic [NUM_REQ*4-1:0]   in_req_oper,
  input  logic [NUM_REQ*2-1:0]   in_req_type_size,
  input  logic [NUM_REQ-1:0]     in_req_signedness,
  output logic                   out_alu_valid,
  output logic [63:0]            out_alu_a,
  output logic [63:0]            out_alu_b,
  output logic [3:0]             out_alu_oper,
  output logic [1:0]             out_alu_type_size,
  output logic                   out_alu_signedness,
  input  logic [63:0]            in_alu_data,
  output logic [NUM_REQ-1:0]     out_res_valid,
  output logic [63:0]            out_res_data,
  output logic                   out_res_illegal
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int DEPTH = ALU_LATENCY + 1;

  logic [IDX_W-1:0] last_grant;
  logic [IDX_W-1:0] grant_idx;
  logic             grant_any;
  logic             handshake;
  int               cand;

  logic [63:0]      sel_a;
  logic [63:0]      sel_b;
  logic [3:0]       sel_oper;
  logic [1:0]       sel_type_size;
  logic             sel_signedness;
  logic             sel_illegal;

  logic             tag_live [DEPTH];
  logic [IDX_W-1:0] tag_idx  [DEPTH];
  logic             tag_ill  [DEPTH];

  // Round-robin search starting just after the last granted requester.
  // The first valid candidate in that rotated order wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(last_grant) + k) % NUM_REQ;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!grant_any && (cand == i) && in_req_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = IDX_W'(i);
        end
      end
    end
  end

  // Ready is held low during reset, so no handshake can happen then.
  always_comb begin
    in_req_ready = '0;
    if (rst_n && grant_any) in_req_ready[grant_idx] = 1'b1;
  end

  assign handshake = rst_n && grant_any;

  // Multiplexer for the winner's request fields.
  always_comb begin
    sel_a          = '0;
    sel_b          = '0;
    sel_oper       = '0;
    sel_type_size  = '0;
    sel_signedness = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_idx == IDX_W'(i)) begin
        sel_a          = in_req_a[i*64 +: 64];
        sel_b          = in_req_b[i*64 +: 64];
        sel_oper       = in_req_oper[i*4 +: 4];
        sel_type_size  = in_req_type_size[i*2 +: 2];
        sel_signedness = in_req_signedness[i];
      end
    end
  end

  // Opcodes 3, 4 and 13..15 are the unused (dummy) encodings.
  assign sel_illegal = (sel_oper == 4'd3) || (sel_oper == 4'd4) || (sel_oper >= 4'd13);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else if (handshake) begin
      last_grant <= grant_idx;
    end
  end

  // Issue stage: rejected or absent operations leave the ALU operands untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_alu_valid      <= 1'b0;
      out_alu_a          <= '0;
      out_alu_b          <= '0;
      out_alu_oper       <= '0;
      out_alu_type_size  <= '0;
      out_alu_signedness <= 1'b0;
    end else begin
      out_alu_valid <= handshake && !sel_illegal;
      if (handshake && !sel_illegal) begin
        out_alu_a          <= sel_a;
        out_alu_b          <= sel_b;
        out_alu_oper       <= sel_oper;
        out_alu_type_size  <= sel_type_size;
        out_alu_signedness <= sel_signedness;
      end
    end
  end

  // The tag pipeline never stalls. Its last stage lines up with in_alu_data
  // for the operation it describes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_live[i] <= 1'b0;
        tag_idx[i]  <= '0;
        tag_ill[i]  <= 1'b0;
      end
    end else begin
      tag_live[0] <= handshake;
      tag_idx[0]  <= grant_idx;
      tag_ill[0]  <= sel_illegal;
      for (int i = 1; i < DEPTH; i++) begin
        tag_live[i] <= tag_live[i-1];
        tag_idx[i]  <= tag_idx[i-1];
        tag_ill[i]  <= tag_ill[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_res_valid   <= '0;
      out_res_data    <= '0;
      out_res_illegal <= 1'b0;
    end else begin
      out_res_valid   <= '0;
      out_res_data    <= '0;
      out_res_illegal <= 1'b0;
      if (tag_live[DEPTH-1]) begin
        out_res_valid[tag_idx[DEPTH-1]] <= 1'b1;
        out_res_illegal                 <= tag_ill[DEPTH-1];
        out_res_data                    <= tag_ill[DEPTH-1] ? 64'd0 : in_alu_data;
      end
    end
  end

endmodule

// File: doc/snow64_alu_arbiter.md
Name: snow64_alu_arbiter

Overview:
- Shares one Snow64 ALU datapath (64-bit a/b, 4-bit oper, 2-bit type_size, signedness) between NUM_REQ requesters.
- Uses round-robin arbitration and a valid/ready request handshake, accepting at most one operation per cycle.
- Tracks in-flight operations with a tag pipeline matched to the ALU latency, and routes each result back to its requester in order.
- Screens out the unused (dummy) opcode encodings.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
ALU_LATENCY, 0, cycles from out_alu_* to matching in_alu_data (0 = combinational ALU)

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
in_req_valid  in  NUM_REQ  per-requester request valid
in_req_ready  out  NUM_REQ  per-requester accept (one-hot or zero)
in_req_a  in  NUM_REQ*64  operand a, requester i at [64i+63:64i]
in_req_b  in  NUM_REQ*64  operand b, same packing
in_req_oper  in  NUM_REQ*4  ALU oper encoding
in_req_type_size  in  NUM_REQ*2  TypSz8/16/32/64 = 0/1/2/3
in_req_signedness  in  NUM_REQ  signedness
out_alu_valid  out  1  issued op is legal and live
out_alu_a, out_alu_b  out  64 each  ALU operands
out_alu_oper  out  4  ALU oper
out_alu_type_size  out  2  ALU type size
out_alu_signedness  out  1  ALU signedness
in_alu_data  in  64  ALU result
out_res_valid  out  NUM_REQ  one-hot: result for requester i this cycle
out_res_data  out  64  result data
out_res_illegal  out  1  result is for a rejected (illegal) oper

Behaviour:
- Reset:
  - Clock: clk. Reset: rst_n, synchronous, active-low.
  - While rst_n=0 at a clk edge, all registered outputs go to 0, all in-flight tags are cleared and the RR pointer is set to NUM_REQ-1, so requester 0 has first priority.
  - in_req_ready is 0 while rst_n=0.
- Arbitration:
  - Combinational round-robin over in_req_valid.
  - Search starts at last_grant+1, mod NUM_REQ.
  - in_req_ready[i]=1 only for the winner. A handshake occurs when valid&ready.
  - last_grant updates on handshake only; with no valid requesters the pointer is held.
- Requester rules: hold valid and all fields stable until ready. Ready depends on valid; no requester may make valid depend on ready.
- Legal opers: 0,1,2,5,6,7,8,9,10,11,12 (Add, Sub, Slt, And, Orr, Xor, Shl, Shr, Inv, Not, AddAgain).
- Illegal opers: 3,4,13,14,15.
- Issue stage (registered):
  - Handshake in cycle c loads out_alu_a/b/oper/type_size/signedness in cycle c+1.
  - out_alu_valid=1 in c+1 only if the oper is legal. For an illegal oper, out_alu_valid=0 and the operand/control registers hold their previous values.
  - With no handshake, out_alu_valid=0 and the other out_alu_* hold.
- Tag pipeline:
  - Depth ALU_LATENCY+1. Each entry is {live, requester index, illegal}.
  - One entry is inserted per handshake and advances every cycle. No stall.
- Result stage (registered):
  - Tag reaching the end in cycle c+1+ALU_LATENCY gives, in c+2+ALU_LATENCY: out_res_valid = one-hot of the index.
  - out_res_data = in_alu_data if legal, 0 if illegal. out_res_illegal = illegal flag.
  - Otherwise out_res_valid=0, out_res_illegal=0, out_res_data=0.
- Throughput and latency: 1 op/cycle sustained. Latency from handshake to result is ALU_LATENCY+2 cycles, for every op. Results return in issue order.
- No result backpressure: requesters must sink out_res_valid in its cycle.
- Reset mid-operation: all tags dropped. No out_res_valid is produced for ops accepted before reset, even if in_alu_data later changes.
- Same requester back-to-back: allowed only if it is the sole valid requester. Otherwise the RR pointer moves on.

Test Plan:
1. Single op, NUM_REQ=4, ALU_LATENCY=0: req0 valid, OpAdd=0, TypSz64, a=5, b=3, handshake in cycle c -> out_alu_valid=1, oper=0, a=5, b=3 in c+1; bench ALU returns 8 -> out_res_valid=4'b0001, data=8 in c+2.
2. All four valid continuously for 8 cycles -> ready order 0,1,2,3,0,1,2,3, one-hot each cycle; out_res_valid follows the same order two cycles later with matching data.
3. Illegal oper: req2 sends oper=3 in cycle c -> out_alu_valid=0 in c+1; out_res_valid=4'b0100, out_res_illegal=1, data=0 in c+2; a following legal op from req3 is unaffected.
4. ALU_LATENCY=3, bench ALU is a 3-cycle pipeline: req1 then req3 back-to-back, OpXor=7, a=0xFF, b=0x0F -> req1 result 0xF0 in c+5, req3 result in c+6, indices correct.
5. Fairness: req1 alone is granted; next cycle req0 and req1 are both valid -> req0 granted, then req1.
6. Reset: rst_n=0 for one cycle while 2 ops are in flight -> next cycle all outputs 0; no out_res_valid for those ops; after release, simultaneous req0..3 -> req0 granted first.
